// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op codes,
// default latencies and FSM state encoding.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTLO  = 3'd5,
        MDU_MTHI  = 3'd6
    } mdu_op_e;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

    // Only mult/multu/div/divu start a multi-cycle operation.
    function automatic logic is_launch_op(input logic [2:0] sel);
        return (sel == MDU_MULT) || (sel == MDU_MULTU) ||
               (sel == MDU_DIV)  || (sel == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// E-stage pipeline <-> MDU signal bundle. The pipeline drives operands and
// controls (master); the MDU returns Busy and the HI/LO views (slave).
interface mdu_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDUsel;
    logic        Start;
    logic        MDU_RDsel;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDU_RD;

    modport master (
        output A, B, MDUsel, Start, MDU_RDsel,
        input  Busy, HI, LO, MDU_RD
    );

    modport slave (
        input  A, B, MDUsel, Start, MDU_RDsel,
        output Busy, HI, LO, MDU_RD
    );
endinterface

// File: rtl/mdu.sv
// Multiply/divide unit: architectural HI/LO, fixed-latency mult/div with
// operands latched at launch, and single-cycle mthi/mtlo while idle.
module mdu #(
    parameter int MULT_CYCLES = mdu_pkg::MULT_CYCLES,
    parameter int DIV_CYCLES  = mdu_pkg::DIV_CYCLES
) (
    input  logic       clk,
    input  logic       reset_n,
    mdu_if.slave       m
);
    import mdu_pkg::*;

    localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    mdu_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    mdu_op_e       op_q, op_d;
    logic [31:0]   a_q, a_d, b_q, b_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;

    logic signed [63:0] sa, sb;
    logic [63:0]        prod_s, prod_u;
    logic               div_zero, div_ovf;
    logic [31:0]        dvs_s, dvs_u;
    logic [31:0]        q_s, r_s, q_u, r_u;

    assign sa     = {{32{a_q[31]}}, a_q};
    assign sb     = {{32{b_q[31]}}, b_q};
    assign prod_s = sa * sb;
    assign prod_u = {32'b0, a_q} * {32'b0, b_q};

    // Dividing the overflow case by 1 yields exactly LO=0x80000000, HI=0;
    // a zero divisor is also steered to 1 so the datapath never sees X.
    assign div_zero = (b_q == 32'd0);
    assign div_ovf  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    assign dvs_s    = (div_zero || div_ovf) ? 32'd1 : b_q;
    assign dvs_u    = div_zero ? 32'd1 : b_q;
    assign q_s      = 32'($signed(a_q) / $signed(dvs_s));
    assign r_s      = 32'($signed(a_q) % $signed(dvs_s));
    assign q_u      = a_q / dvs_u;
    assign r_u      = a_q % dvs_u;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= MDU_NONE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (m.Start && is_launch_op(m.MDUsel)) begin
                    a_d     = m.A;
                    b_d     = m.B;
                    op_d    = mdu_op_e'(m.MDUsel);
                    cnt_d   = (m.MDUsel == MDU_MULT || m.MDUsel == MDU_MULTU) ?
                              CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                    state_d = RUN;
                end else if (m.MDUsel == MDU_MTLO) begin
                    lo_d = m.A;
                end else if (m.MDUsel == MDU_MTHI) begin
                    hi_d = m.A;
                end
            end
            RUN: begin
                // Control inputs are deliberately ignored here; hazard logic stalls them.
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    case (op_q)
                        MDU_MULT:  {hi_d, lo_d} = prod_s;
                        MDU_MULTU: {hi_d, lo_d} = prod_u;
                        MDU_DIV:   if (!div_zero) begin
                            lo_d = q_s;
                            hi_d = r_s;
                        end
                        MDU_DIVU:  if (!div_zero) begin
                            lo_d = q_u;
                            hi_d = r_u;
                        end
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m.Busy   = (state_q == RUN);
    assign m.HI     = hi_q;
    assign m.LO     = lo_q;
    assign m.MDU_RD = m.MDU_RDsel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: a cycle-indexed behavioural model of HI/LO/Busy is
// compared every cycle, and each directed op also checks hand-computed results.
module tb_mdu;

    localparam int N_MULT = 5;
    localparam int N_DIV  = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    mdu_if bus();

    mdu dut (
        .clk     (clk),
        .reset_n (reset_n),
        .m       (bus)
    );

    always #5 clk = ~clk;

    // Model: a launch at the edge closing cycle T commits at the edge closing T+N.
    logic [31:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0;
    logic [2:0]  m_op = '0;
    logic        m_pend = 1'b0;
    int          m_cyc = 0, m_done = 0;

    function automatic logic [63:0] model_res(input logic [2:0] op,
                                              input logic [31:0] a, b, hi, lo);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        model_res = {hi, lo};
        case (op)
            3'd1: model_res = 64'(longint'(sa) * longint'(sb));
            3'd2: model_res = {32'b0, a} * {32'b0, b};
            3'd3: if (b != 0) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    model_res = {32'h0, 32'h8000_0000};
                else
                    model_res = {32'(sa % sb), 32'(sa / sb)};
            end
            3'd4: if (b != 0) model_res = {a % b, a / b};
            default: ;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_pend <= 1'b0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_pend) begin
                if (m_cyc == m_done) begin
                    {m_hi, m_lo} <= model_res(m_op, m_a, m_b, m_hi, m_lo);
                    m_pend       <= 1'b0;
                end
            end else if (bus.Start && (bus.MDUsel inside {[3'd1:3'd4]})) begin
                m_pend <= 1'b1;
                m_a    <= bus.A;
                m_b    <= bus.B;
                m_op   <= bus.MDUsel;
                m_done <= m_cyc + ((bus.MDUsel <= 3'd2) ? N_MULT : N_DIV);
            end else if (bus.MDUsel == 3'd5) begin
                m_lo <= bus.A;
            end else if (bus.MDUsel == 3'd6) begin
                m_hi <= bus.A;
            end
        end
    end

    int   n_cmp = 0, n_bad = 0;
    logic last_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: compare against the model mid-cycle, then step past the edge.
    task automatic cycle();
        @(negedge clk);
        if (reset_n) begin
            chk("busy",   32'(bus.Busy), 32'(m_pend));
            chk("hi",     bus.HI, m_hi);
            chk("lo",     bus.LO, m_lo);
            chk("mdu_rd", bus.MDU_RD, bus.MDU_RDsel ? m_hi : m_lo);
        end
        last_busy = bus.Busy;
        @(posedge clk);
        #1;
        bus.MDU_RDsel = ~bus.MDU_RDsel;
    endtask

    task automatic idle();
        bus.Start  = 1'b0;
        bus.MDUsel = 3'd0;
    endtask

    task automatic move_to(input logic [2:0] op, input logic [31:0] a);
        bus.MDUsel = op;
        bus.A      = a;
        cycle();
        idle();
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n_exp, input logic [31:0] hi_exp,
                          input logic [31:0] lo_exp, input bit intf);
        int n;
        bus.A = a; bus.B = b; bus.MDUsel = op; bus.Start = 1'b1;
        cycle();
        idle();
        n = 0;
        if (intf) begin
            bus.MDUsel = 3'd5; bus.A = 32'hDEAD_BEEF;
            cycle();
            if (last_busy) n++;
            bus.MDUsel = 3'd1; bus.Start = 1'b1; bus.A = 32'd7; bus.B = 32'd7;
            cycle();
            if (last_busy) n++;
            idle();
        end
        bus.A = $urandom; bus.B = $urandom;
        do begin
            cycle();
            if (last_busy) n++;
        end while (last_busy && n < 40);
        chk({name, "_busy_cycles"}, 32'(n), 32'(n_exp));
        chk({name, "_hi"}, bus.HI, hi_exp);
        chk({name, "_lo"}, bus.LO, lo_exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bus.A = '0; bus.B = '0; bus.MDUsel = '0; bus.Start = 1'b0; bus.MDU_RDsel = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("rst_hi", bus.HI, 32'h0);
        chk("rst_lo", bus.LO, 32'h0);
        chk("rst_busy", 32'(bus.Busy), 32'h0);
        cycle();

        move_to(3'd6, 32'hAAAA_0000);
        chk("mthi_hi", bus.HI, 32'hAAAA_0000);
        chk("mthi_busy", 32'(bus.Busy), 32'h0);
        move_to(3'd5, 32'h0000_1234);
        chk("mtlo_lo", bus.LO, 32'h0000_1234);

        // Asynchronous reset pulse in the middle of a cycle.
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 chk("apulse_hi", bus.HI, 32'h0);
        chk("apulse_lo", bus.LO, 32'h0);
        chk("apulse_busy", 32'(bus.Busy), 32'h0);
        bus.MDU_RDsel = 1'b1;
        #1 chk("apulse_rd_hi", bus.MDU_RD, 32'h0);
        bus.MDU_RDsel = 1'b0;
        #1 chk("apulse_rd_lo", bus.MDU_RD, 32'h0);
        reset_n = 1'b1;
        cycle();

        run_op("mult",   3'd1, 32'hFFFF_FFFE, 32'd3,         N_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        run_op("multu",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, N_MULT, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("div",    3'd3, 32'hFFFF_FFF9, 32'd2,         N_DIV,  32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        move_to(3'd6, 32'h11);
        move_to(3'd5, 32'h22);
        run_op("divu0",  3'd4, 32'd5,         32'd0,         N_DIV,  32'h11,        32'h22,        1'b0);
        run_op("divovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, N_DIV,  32'h0,         32'h8000_0000, 1'b0);
        run_op("divu",   3'd4, 32'd100,       32'd7,         N_DIV,  32'd2,         32'd14,        1'b0);
        run_op("divubig",3'd4, 32'h8000_0000, 32'hFFFF_FFFF, N_DIV,  32'h8000_0000, 32'h0,         1'b0);
        run_op("intf",   3'd1, 32'd3,         32'd4,         N_MULT, 32'h0,         32'd12,        1'b1);

        // Reset during cycle T+3 of a mult must abort it with no later write.
        bus.A = 32'd5; bus.B = 32'd6; bus.MDUsel = 3'd1; bus.Start = 1'b1;
        cycle();
        idle();
        cycle();
        cycle();
        #2 reset_n = 1'b0;
        #1 chk("abort_hi", bus.HI, 32'h0);
        chk("abort_lo", bus.LO, 32'h0);
        chk("abort_busy", 32'(bus.Busy), 32'h0);
        #1 reset_n = 1'b1;
        repeat (8) cycle();
        chk("abort_late_hi", bus.HI, 32'h0);
        chk("abort_late_lo", bus.LO, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
